core_run_ctrl: RTL and testbench
================================

# core_run_ctrl

Run/step/halt sequencer for the multi-cycle RV32I core. It sits between the board-level or debug controls and the core's `reset`/`run` inputs. It owns core reset sequencing, free-run, single-instruction step, PC breakpoint, a cycle watchdog, and the cycle and retired-instruction counters that firmware and benches read.

## Interface
- `FETCH_STATE`, 4'd0: core control-unit state encoding for instruction fetch, which marks the instruction boundary.
- `RESET_CYCLES`, 2: number of cycles `core_reset` is held when a fresh run starts; legal range 1..15.
- `MAX_CYCLES`, 32'd100000: watchdog limit on `cycles`; 0 disables the watchdog.

- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low block reset.
- `start` in 1: pulse; starts a fresh run from IDLE, or resumes from HALTED.
- `step` in 1: pulse; executes exactly one instruction from IDLE or HALTED.
- `halt_req` in 1: level; requests a stop at the next instruction boundary.
- `clear` in 1: pulse; HALTED → IDLE; clears `halt_cause`.
- `bp_valid` in 1: breakpoint enable.
- `bp_addr` in 32: breakpoint PC, compared against `core_pc`.
- `core_done` in 1: core end-of-program flag.
- `core_state` in 4: core control-unit state.
- `core_pc` in 32: core PC.
- `core_reset` out 1: active-high reset driven to the core.
- `core_run` out 1: core advances only while this is 1.
- `busy` out 1: high in RESET_CORE, RUN and STEP.
- `halted` out 1: high in HALTED.
- `halt_cause` out 3: 0 none, 1 done, 2 step, 3 breakpoint, 4 watchdog, 5 halt_req.
- `cycles` out 32: count of cycles with `core_run`=1.
- `instret` out 32: count of retired instructions.

## Operation
- The FSM has five states: IDLE, RESET_CORE, RUN, STEP, HALTED. All outputs are registered.
- Reset (`reset`=0), applied asynchronously:
  - state = IDLE, `core_reset`=1, `core_run`=0, `busy`=0, `halted`=0.
  - `halt_cause`=0, `cycles`=0, `instret`=0.
- IDLE:
  - `core_reset`=1.
  - On `start` or `step` → RESET_CORE; the pending mode (run or step) is latched.
  - `start` wins if both are asserted in the same cycle.
- RESET_CORE:
  - `core_reset`=1 for exactly `RESET_CYCLES` cycles.
  - Counters are cleared on entry.
  - Then → RUN or STEP according to the latched mode.
- RUN: `core_run`=1. Each cycle, halt conditions are evaluated in this priority order:
  - `core_done` → cause 1.
  - `cycles`==`MAX_CYCLES`-1 with the watchdog enabled → cause 4.
  - Breakpoint hit → cause 3.
  - `halt_req` while `core_state`==`FETCH_STATE` → cause 5.
  - The first matching condition moves the FSM to HALTED and sets the cause.
- STEP:
  - `core_run`=1 until `core_state` leaves `FETCH_STATE` and then re-enters it. That re-entry cycle is the boundary; → HALTED with cause 2.
  - `core_done`, watchdog, or breakpoint hits during STEP override cause 2 using the same priority order.
- HALTED:
  - `core_run`=0; core state is preserved and `core_reset`=0.
  - `start` → RUN (resume) and `step` → STEP; neither resets the core or the counters. Both clear `halt_cause` to 0 on exit.
  - `clear` → IDLE.
  - After cause 1 (done), `start` and `step` are ignored; only `clear` leaves HALTED.
- Breakpoint hit: `bp_valid` && `core_state`==`FETCH_STATE` && `core_pc`==`bp_addr` && not the first boundary after entering RUN. This lets a resume step past the breakpoint it stopped on.
- `instret` increments on each cycle where `core_run`=1 and `core_state` transitions into `FETCH_STATE` from any other state.
- Both counters wrap modulo 2^32. `cycles` increments on every cycle with `core_run`=1, including the halting cycle.
- `start`, `step` and `clear` are ignored while `busy`=1.

## Timing
- `start` sampled in IDLE at edge N:
  - `core_reset` stays high through edge N+`RESET_CYCLES`.
  - `core_run` rises after edge N+`RESET_CYCLES`+1 and `busy` rises after edge N+1.
- A halt condition sampled at edge M gives `core_run`=0, `halted`=1 and a valid `halt_cause` after edge M. The core therefore executes at most the cycle on which the condition was detected.
- Resume from HALTED: `core_run`=1 one cycle after the `start` pulse.
- `reset` asserted mid-run forces IDLE values immediately, with no clock required. Deassertion takes effect synchronously at the next edge.

## Configuration
- `RUN_CTRL_BREAKPOINT_EN`
  - Defined: the breakpoint compare and the skip-first-boundary logic are present.
  - Undefined: `bp_valid` and `bp_addr` are ignored, cause 3 is never produced, and the comparator is removed.

## Test plan
- Reset with `RESET_CYCLES`=2, then `start` pulse → `core_reset` high for 2 cycles, then `core_run`=1; `cycles` increments from 0.
- A program reaching `core_done` at `instret`=12 → `halted`=1, `halt_cause`=1, `instret`=12; a subsequent `start` is ignored, and `clear` → IDLE.
- `bp_addr`=0x10, `bp_valid`=1:
  - Run → halt with cause 3 and `core_pc`=0x10.
  - `start` → run continues past 0x10 and halts at the next hit or at done.
- `step` from HALTED, three times → each step advances `instret` by exactly 1 with `halt_cause`=2.
- `MAX_CYCLES`=50 on an infinite loop → halt with cause 4 and `cycles`=50.
- `reset` low in the middle of RUN → `core_run`=0, `core_reset`=1 and counters at 0 before the next clock edge.

Source files
------------

// File: rtl/core_run_ctrl_if.sv
// Control, status and core-side signals of the run/step/halt sequencer.
// slave is the sequencer's view; master is the debug/board/core side.
interface core_run_ctrl_if;
  logic        start;
  logic        step;
  logic        halt_req;
  logic        clear;
  logic        bp_valid;
  logic [31:0] bp_addr;
  logic        core_done;
  logic [3:0]  core_state;
  logic [31:0] core_pc;
  logic        core_reset;
  logic        core_run;
  logic        busy;
  logic        halted;
  logic [2:0]  halt_cause;
  logic [31:0] cycles;
  logic [31:0] instret;

  modport slave (
    input  start, step, halt_req, clear, bp_valid, bp_addr,
           core_done, core_state, core_pc,
    output core_reset, core_run, busy, halted, halt_cause, cycles, instret
  );

  modport master (
    output start, step, halt_req, clear, bp_valid, bp_addr,
           core_done, core_state, core_pc,
    input  core_reset, core_run, busy, halted, halt_cause, cycles, instret
  );
endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/step/halt sequencer driving the RV32I core's reset and run inputs.
// The PC breakpoint is built only when RUN_CTRL_BREAKPOINT_EN is defined.
module core_run_ctrl #(
  parameter logic [3:0]  FETCH_STATE  = 4'd0,
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [31:0] MAX_CYCLES   = 32'd100000
) (
  input  logic           clock,
  input  logic           reset,
  core_run_ctrl_if.slave ctl
);
  typedef enum logic [2:0] {
    S_IDLE, S_RESET_CORE, S_RUN, S_STEP, S_HALTED
  } state_t;

  localparam logic [2:0]  CAUSE_NONE = 3'd0;
  localparam logic [2:0]  CAUSE_DONE = 3'd1;
  localparam logic [2:0]  CAUSE_STEP = 3'd2;
  localparam logic [2:0]  CAUSE_BP   = 3'd3;
  localparam logic [2:0]  CAUSE_WDOG = 3'd4;
  localparam logic [2:0]  CAUSE_HREQ = 3'd5;
  localparam logic [3:0]  RC_LAST    = 4'(RESET_CYCLES - 1);
  localparam logic [31:0] WD_LIMIT   = MAX_CYCLES - 32'd1;
  localparam logic        WD_EN      = (MAX_CYCLES != 32'd0);

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic        mode_step_q, mode_step_d;
  logic [3:0]  rst_cnt_q, rst_cnt_d;
  logic        left_fetch_q, left_fetch_d;
  logic [3:0]  prev_state_q, prev_state_d;
  logic        core_reset_q, core_reset_d;
  logic        core_run_q, core_run_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;
  logic [2:0]  halt_cause_q, halt_cause_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] instret_q, instret_d;

  logic        fetch_now, fetch_entry, wd_hit, bp_hit, entering_run;
  logic [2:0]  cause_sel;

  // First matching halt condition wins.
  function automatic logic [2:0] pick_cause(input logic done, input logic wd, input logic bp,
                                            input logic hreq, input logic stepb);
    if (done)  return CAUSE_DONE;
    if (wd)    return CAUSE_WDOG;
    if (bp)    return CAUSE_BP;
    if (hreq)  return CAUSE_HREQ;
    if (stepb) return CAUSE_STEP;
    return CAUSE_NONE;
  endfunction

  assign fetch_now    = (ctl.core_state == FETCH_STATE);
  assign fetch_entry  = fetch_now && (prev_state_q != FETCH_STATE);
  assign wd_hit       = WD_EN && (cycles_q == WD_LIMIT);
  assign entering_run = ((state_d == S_RUN) || (state_d == S_STEP)) && (state_d != state_q);

`ifdef RUN_CTRL_BREAKPOINT_EN
  // skip stays set until the core has been seen at a fetch and then left it.
  logic skip_q, skip_d, seen_q, seen_d;

  assign bp_hit = ctl.bp_valid && fetch_now && (ctl.core_pc == ctl.bp_addr) && !skip_q;

  always_comb begin
    skip_d = skip_q;
    seen_d = seen_q;
    if (entering_run) begin
      skip_d = 1'b1;
      seen_d = 1'b0;
    end else if ((state_q == S_RUN) || (state_q == S_STEP)) begin
      if (fetch_now)   seen_d = 1'b1;
      else if (seen_q) skip_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      skip_q <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
      seen_q <= seen_d;
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{ctl.bp_valid, ctl.bp_addr};
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    mode_step_d  = mode_step_q;
    rst_cnt_d    = rst_cnt_q;
    left_fetch_d = left_fetch_q;
    halt_cause_d = halt_cause_q;
    cycles_d     = cycles_q;
    instret_d    = instret_q;
    prev_state_d = ctl.core_state;
    cause_sel    = pick_cause(ctl.core_done, wd_hit, bp_hit,
                              (state_q == S_RUN) && ctl.halt_req && fetch_now,
                              (state_q == S_STEP) && left_fetch_q && fetch_now);
    case (state_q)
      S_IDLE: begin
        // The request is latched first and acted on one cycle later.
        if (pend_q) begin
          state_d   = S_RESET_CORE;
          pend_d    = 1'b0;
          rst_cnt_d = 4'd0;
        end else if (ctl.start || ctl.step) begin
          pend_d      = 1'b1;
          mode_step_d = !ctl.start;
        end
      end
      S_RESET_CORE: begin
        if (rst_cnt_q == RC_LAST) state_d = mode_step_q ? S_STEP : S_RUN;
        else                      rst_cnt_d = rst_cnt_q + 4'd1;
      end
      S_RUN, S_STEP: begin
        if ((state_q == S_STEP) && !fetch_now) left_fetch_d = 1'b1;
        if (cause_sel != CAUSE_NONE) begin
          state_d      = S_HALTED;
          halt_cause_d = cause_sel;
        end
      end
      S_HALTED: begin
        if (ctl.clear) begin
          state_d      = S_IDLE;
          halt_cause_d = CAUSE_NONE;
        end else if (halt_cause_q != CAUSE_DONE) begin
          if (ctl.start) begin
            state_d      = S_RUN;
            halt_cause_d = CAUSE_NONE;
          end else if (ctl.step) begin
            state_d      = S_STEP;
            halt_cause_d = CAUSE_NONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_STEP) && (state_q != S_STEP)) left_fetch_d = 1'b0;

    if ((state_d == S_RESET_CORE) && (state_q != S_RESET_CORE)) begin
      cycles_d  = 32'd0;
      instret_d = 32'd0;
    end else if (core_run_q) begin
      cycles_d = cycles_q + 32'd1;
      if (fetch_entry) instret_d = instret_q + 32'd1;
    end

    core_reset_d = (state_d == S_IDLE) || (state_d == S_RESET_CORE);
    core_run_d   = (state_d == S_RUN) || (state_d == S_STEP);
    busy_d       = (state_d == S_RESET_CORE) || core_run_d;
    halted_d     = (state_d == S_HALTED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      mode_step_q  <= 1'b0;
      rst_cnt_q    <= 4'd0;
      left_fetch_q <= 1'b0;
      prev_state_q <= FETCH_STATE;
      core_reset_q <= 1'b1;
      core_run_q   <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      halt_cause_q <= CAUSE_NONE;
      cycles_q     <= 32'd0;
      instret_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      mode_step_q  <= mode_step_d;
      rst_cnt_q    <= rst_cnt_d;
      left_fetch_q <= left_fetch_d;
      prev_state_q <= prev_state_d;
      core_reset_q <= core_reset_d;
      core_run_q   <= core_run_d;
      busy_q       <= busy_d;
      halted_q     <= halted_d;
      halt_cause_q <= halt_cause_d;
      cycles_q     <= cycles_d;
      instret_q    <= instret_d;
    end
  end

  assign ctl.core_reset = core_reset_q;
  assign ctl.core_run   = core_run_q;
  assign ctl.busy       = busy_q;
  assign ctl.halted     = halted_q;
  assign ctl.halt_cause = halt_cause_q;
  assign ctl.cycles     = cycles_q;
  assign ctl.instret    = instret_q;
endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl driving a 4-state toy core model (one instruction per
// four cycles, PC += 4). dut_a runs a 12-instruction program; dut_w spins with a 50-cycle watchdog.
module tb_core_run_ctrl;
  logic clock = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  core_run_ctrl_if ia ();
  core_run_ctrl_if iw ();

  core_run_ctrl #(.FETCH_STATE(4'd0), .RESET_CYCLES(2), .MAX_CYCLES(32'd100000)) dut_a (
    .clock(clock), .reset(reset), .ctl(ia.slave));
  core_run_ctrl #(.FETCH_STATE(4'd0), .RESET_CYCLES(2), .MAX_CYCLES(32'd50)) dut_w (
    .clock(clock), .reset(reset), .ctl(iw.slave));

  localparam logic [31:0] DONE_PC = 32'h30;
  logic [3:0]  st_a, st_w;
  logic [31:0] pc_a;

  // Toy core: states 0..3, state 0 is fetch; PC advances when leaving state 3.
  always_ff @(posedge clock) begin
    if (ia.core_reset) begin
      st_a <= 4'd0;
      pc_a <= 32'd0;
    end else if (ia.core_run) begin
      st_a <= (st_a == 4'd3) ? 4'd0 : st_a + 4'd1;
      if (st_a == 4'd3) pc_a <= pc_a + 32'd4;
    end
  end
  assign ia.core_state = st_a;
  assign ia.core_pc    = pc_a;
  assign ia.core_done  = (pc_a == DONE_PC);

  // Infinite loop: branch-to-self at PC 0, never done.
  always_ff @(posedge clock) begin
    if (iw.core_reset)    st_w <= 4'd0;
    else if (iw.core_run) st_w <= (st_w == 4'd3) ? 4'd0 : st_w + 4'd1;
  end
  assign iw.core_state = st_w;
  assign iw.core_pc    = 32'd0;
  assign iw.core_done  = 1'b0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_a_start();
    ia.start = 1'b1; tick(); ia.start = 1'b0;
  endtask

  task automatic pulse_a_step();
    ia.step = 1'b1; tick(); ia.step = 1'b0;
  endtask

  task automatic pulse_a_clear();
    ia.clear = 1'b1; tick(); ia.clear = 1'b0;
  endtask

  task automatic wait_a_halted(input int budget, output bit ok);
    for (int i = 0; i < budget && !ia.halted; i++) tick();
    ok = ia.halted;
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b0;
    repeat (3) tick();
    n_chk++; if (ia.core_reset !== 1'b1) begin n_fail++; $display("FAIL rst_core_reset got %0b want 1", ia.core_reset); end
    n_chk++; if (ia.core_run !== 1'b0) begin n_fail++; $display("FAIL rst_core_run got %0b want 0", ia.core_run); end
    n_chk++; if (ia.busy !== 1'b0 || ia.halted !== 1'b0) begin n_fail++; $display("FAIL rst_busy_halted got %0b%0b want 00", ia.busy, ia.halted); end
    n_chk++; if (ia.halt_cause !== 3'd0) begin n_fail++; $display("FAIL rst_cause got %0d want 0", ia.halt_cause); end
    n_chk++; if (ia.cycles !== 32'd0 || ia.instret !== 32'd0) begin n_fail++; $display("FAIL rst_counters got %0d/%0d want 0/0", ia.cycles, ia.instret); end
    reset = 1'b1;
    tick();
    ok = ia.core_reset && !ia.busy;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL rst_release_idle got reset=%0b busy=%0b want 1/0", ia.core_reset, ia.busy); end
  endtask

  task automatic test_start_timing();
    pulse_a_start();
    n_chk++; if (ia.busy !== 1'b0 || ia.core_reset !== 1'b1) begin n_fail++; $display("FAIL t_n busy/reset got %0b/%0b want 0/1", ia.busy, ia.core_reset); end
    tick();
    n_chk++; if (ia.busy !== 1'b1 || ia.core_reset !== 1'b1 || ia.core_run !== 1'b0) begin n_fail++; $display("FAIL t_n1 busy/reset/run got %0b/%0b/%0b want 1/1/0", ia.busy, ia.core_reset, ia.core_run); end
    tick();
    n_chk++; if (ia.core_reset !== 1'b1 || ia.core_run !== 1'b0) begin n_fail++; $display("FAIL t_n2 reset/run got %0b/%0b want 1/0", ia.core_reset, ia.core_run); end
    tick();
    n_chk++; if (ia.core_reset !== 1'b0 || ia.core_run !== 1'b1 || ia.cycles !== 32'd0) begin n_fail++; $display("FAIL t_n3 reset/run/cycles got %0b/%0b/%0d want 0/1/0", ia.core_reset, ia.core_run, ia.cycles); end
    tick();
    n_chk++; if (ia.cycles !== 32'd1) begin n_fail++; $display("FAIL t_cycles1 got %0d want 1", ia.cycles); end
    tick();
    pulse_a_start();
    n_chk++; if (ia.cycles !== 32'd3 || ia.busy !== 1'b1 || ia.halted !== 1'b0) begin n_fail++; $display("FAIL busy_ignore got cyc=%0d busy=%0b halted=%0b want 3/1/0", ia.cycles, ia.busy, ia.halted); end
  endtask

  task automatic test_done();
    bit ok;
    wait_a_halted(200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL done_timeout halted=%0b want 1", ia.halted); end
    n_chk++; if (ia.halt_cause !== 3'd1) begin n_fail++; $display("FAIL done_cause got %0d want 1", ia.halt_cause); end
    n_chk++; if (ia.instret !== 32'd12 || ia.cycles !== 32'd49) begin n_fail++; $display("FAIL done_counters got %0d/%0d want 12/49", ia.instret, ia.cycles); end
    n_chk++; if (ia.core_run !== 1'b0 || ia.core_reset !== 1'b0 || ia.busy !== 1'b0) begin n_fail++; $display("FAIL done_outputs run/reset/busy got %0b/%0b/%0b want 0/0/0", ia.core_run, ia.core_reset, ia.busy); end
    pulse_a_start(); tick();
    pulse_a_step(); tick();
    n_chk++; if (ia.halted !== 1'b1 || ia.core_run !== 1'b0 || ia.halt_cause !== 3'd1 || ia.cycles !== 32'd49) begin n_fail++; $display("FAIL done_sticky halted=%0b run=%0b cause=%0d cyc=%0d want 1/0/1/49", ia.halted, ia.core_run, ia.halt_cause, ia.cycles); end
    pulse_a_clear();
    n_chk++; if (ia.halted !== 1'b0 || ia.halt_cause !== 3'd0 || ia.core_reset !== 1'b1 || ia.busy !== 1'b0) begin n_fail++; $display("FAIL clear_idle halted=%0b cause=%0d reset=%0b busy=%0b want 0/0/1/0", ia.halted, ia.halt_cause, ia.core_reset, ia.busy); end
  endtask

  task automatic test_breakpoint();
    bit ok;
    ia.bp_addr  = 32'h10;
    ia.bp_valid = 1'b1;
    pulse_a_start();
    wait_a_halted(200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_timeout halted=%0b want 1", ia.halted); end
`ifdef RUN_CTRL_BREAKPOINT_EN
    n_chk++; if (ia.halt_cause !== 3'd3 || ia.core_pc !== 32'h10) begin n_fail++; $display("FAIL bp_hit cause=%0d pc=%0h want 3/10", ia.halt_cause, ia.core_pc); end
    n_chk++; if (ia.instret !== 32'd4 || ia.cycles !== 32'd17) begin n_fail++; $display("FAIL bp_counters got %0d/%0d want 4/17", ia.instret, ia.cycles); end
    pulse_a_start();
    n_chk++; if (ia.core_run !== 1'b1 || ia.halted !== 1'b0 || ia.halt_cause !== 3'd0) begin n_fail++; $display("FAIL bp_resume run=%0b halted=%0b cause=%0d want 1/0/0", ia.core_run, ia.halted, ia.halt_cause); end
    wait_a_halted(200, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_resume_timeout halted=%0b want 1", ia.halted); end
`endif
    n_chk++; if (ia.halt_cause !== 3'd1 || ia.instret !== 32'd12 || ia.cycles !== 32'd49) begin n_fail++; $display("FAIL bp_final cause=%0d instret=%0d cyc=%0d want 1/12/49", ia.halt_cause, ia.instret, ia.cycles); end
    ia.bp_valid = 1'b0;
    pulse_a_clear();
  endtask

  task automatic test_step();
    bit ok;
    pulse_a_step();
    wait_a_halted(100, ok);
    n_chk++; if (!ok || ia.halt_cause !== 3'd2 || ia.instret !== 32'd1 || ia.cycles !== 32'd5) begin n_fail++; $display("FAIL step_idle ok=%0b cause=%0d instret=%0d cyc=%0d want 1/2/1/5", ok, ia.halt_cause, ia.instret, ia.cycles); end
    for (int i = 0; i < 3; i++) begin
      pulse_a_step();
      n_chk++; if (ia.core_run !== 1'b1 || ia.halt_cause !== 3'd0) begin n_fail++; $display("FAIL step_exit%0d run=%0b cause=%0d want 1/0", i, ia.core_run, ia.halt_cause); end
      wait_a_halted(100, ok);
      n_chk++; if (!ok || ia.halt_cause !== 3'd2 || ia.instret !== 32'(2 + i) || ia.cycles !== 32'(9 + 4 * i)) begin
        n_fail++; $display("FAIL step%0d ok=%0b cause=%0d instret=%0d cyc=%0d want 1/2/%0d/%0d", i, ok, ia.halt_cause, ia.instret, ia.cycles, 2 + i, 9 + 4 * i);
      end
    end
  endtask

  task automatic test_halt_req();
    bit ok;
    ia.halt_req = 1'b1;
    pulse_a_start();
    wait_a_halted(100, ok);
    ia.halt_req = 1'b0;
    n_chk++; if (!ok || ia.halt_cause !== 3'd5 || ia.instret !== 32'd5 || ia.cycles !== 32'd21) begin n_fail++; $display("FAIL halt_req ok=%0b cause=%0d instret=%0d cyc=%0d want 1/5/5/21", ok, ia.halt_cause, ia.instret, ia.cycles); end
    pulse_a_clear();
  endtask

  task automatic test_watchdog();
    int i;
    iw.start = 1'b1; tick(); iw.start = 1'b0;
    for (i = 0; i < 200 && !iw.halted; i++) tick();
    n_chk++; if (iw.halted !== 1'b1) begin n_fail++; $display("FAIL wdog_timeout halted=%0b want 1", iw.halted); end
    n_chk++; if (iw.halt_cause !== 3'd4 || iw.cycles !== 32'd50 || iw.instret !== 32'd12) begin n_fail++; $display("FAIL wdog cause=%0d cyc=%0d instret=%0d want 4/50/12", iw.halt_cause, iw.cycles, iw.instret); end
    n_chk++; if (iw.core_run !== 1'b0) begin n_fail++; $display("FAIL wdog_run got %0b want 0", iw.core_run); end
  endtask

  task automatic test_reset_midrun();
    pulse_a_start();
    repeat (13) tick();
    n_chk++; if (ia.core_run !== 1'b1 || ia.cycles !== 32'd10) begin n_fail++; $display("FAIL mid_pre run=%0b cyc=%0d want 1/10", ia.core_run, ia.cycles); end
    #2 reset = 1'b0;
    #1;
    n_chk++; if (ia.core_run !== 1'b0 || ia.core_reset !== 1'b1) begin n_fail++; $display("FAIL mid_async run/reset got %0b/%0b want 0/1", ia.core_run, ia.core_reset); end
    n_chk++; if (ia.cycles !== 32'd0 || ia.instret !== 32'd0 || ia.busy !== 1'b0) begin n_fail++; $display("FAIL mid_async cyc/instret/busy got %0d/%0d/%0b want 0/0/0", ia.cycles, ia.instret, ia.busy); end
    n_chk++; if (iw.halted !== 1'b0 || iw.halt_cause !== 3'd0) begin n_fail++; $display("FAIL mid_async_w halted/cause got %0b/%0d want 0/0", iw.halted, iw.halt_cause); end
    tick();
    reset = 1'b1;
    tick();
    n_chk++; if (ia.core_reset !== 1'b1 || ia.busy !== 1'b0 || ia.core_run !== 1'b0) begin n_fail++; $display("FAIL mid_release reset/busy/run got %0b/%0b/%0b want 1/0/0", ia.core_reset, ia.busy, ia.core_run); end
  endtask

  initial begin
    reset = 1'b0;
    {ia.start, ia.step, ia.halt_req, ia.clear, ia.bp_valid} = '0;
    {iw.start, iw.step, iw.halt_req, iw.clear, iw.bp_valid} = '0;
    ia.bp_addr = 32'd0;
    iw.bp_addr = 32'd0;
    test_reset();
    test_start_timing();
    test_done();
    test_breakpoint();
    test_step();
    test_halt_req();
    test_watchdog();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish within 200000 time units");
    $fatal(1, "tb_core_run_ctrl stopped on time limit");
  end
endmodule
